// File: rtl/fq_drr.sv
// rtl/fq_drr.sv - deficit round-robin scheduler merging N packet FIFOs onto one registered stream
// Define FQ_STATS_EN to add per-channel packet/word counters read back through stat_sel.
module fq_drr #(
  parameter int NUM_IN_LOG2 = 3,
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 8,
  parameter int QUANTUM     = 16,
  parameter int DEF_W       = 12
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic [(1<<NUM_IN_LOG2)-1:0]           fifo_rdreq,
  input  logic [(1<<NUM_IN_LOG2)-1:0]           fifo_empty,
  input  logic [(1<<NUM_IN_LOG2)*DATA_W-1:0]    fifo_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic                                  out_sop,
  output logic                                  out_eop,
  output logic [NUM_IN_LOG2-1:0]                out_chan
`ifdef FQ_STATS_EN
  ,
  input  logic [NUM_IN_LOG2-1:0]                stat_sel,
  output logic [31:0]                           stat_pkts,
  output logic [31:0]                           stat_words,
  input  logic                                  stat_clr
`endif
);

  localparam int N = 1 << NUM_IN_LOG2;
  localparam logic [DEF_W-1:0] DEF_MAX = {DEF_W{1'b1}};
  localparam logic [DEF_W:0]   QUANT_X = (DEF_W+1)'(QUANTUM);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_NEXT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_IN_LOG2-1:0] rr_q, rr_d;
  logic [NUM_IN_LOG2-1:0] cur_q, cur_d;
  logic [DEF_W-1:0]       deficit_q [N];
  logic [DEF_W-1:0]       deficit_d [N];
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [NUM_IN_LOG2-1:0] out_chan_q, out_chan_d;

  logic [DATA_W-1:0]      cur_word;
  logic [CNT_W-1:0]       rr_len, cur_len;
  logic [DEF_W:0]         def_sum;
  logic [DEF_W-1:0]       def_sat;
  logic                   ld;
  logic                   last_word;

  // A zero length field still carries the header itself, so it counts as one word.
  function automatic logic [CNT_W-1:0] hdr_len(input logic [CNT_W-1:0] f);
    hdr_len = (f == '0) ? CNT_W'(1) : f;
  endfunction

  assign cur_word = fifo_data[int'(cur_q)*DATA_W +: DATA_W];
  assign cur_len  = hdr_len(cur_word[CNT_W-1:0]);
  assign rr_len   = hdr_len(fifo_data[int'(rr_q)*DATA_W +: CNT_W]);

  assign def_sum  = {1'b0, deficit_q[rr_q]} + QUANT_X;
  assign def_sat  = def_sum[DEF_W] ? DEF_MAX : def_sum[DEF_W-1:0];

  assign ld        = (!out_valid_q || out_ready) && (state_q == S_SEND) && !fifo_empty[cur_q];
  assign last_word = (wcnt_q == len_q - 1'b1);

  always_comb begin
    fifo_rdreq        = '0;
    fifo_rdreq[cur_q] = ld;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cur_d       = cur_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    for (int i = 0; i < N; i++) deficit_d[i] = deficit_q[i];
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;

    if (ld) begin
      out_valid_d = 1'b1;
      out_data_d  = cur_word;
      out_sop_d   = (wcnt_q == '0);
      out_eop_d   = last_word;
      out_chan_d  = cur_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!(&fifo_empty)) state_d = S_ARB;
      end
      S_ARB: begin
        if (fifo_empty[rr_q]) begin
          deficit_d[rr_q] = '0;
          rr_d            = rr_q + 1'b1;
          if (&fifo_empty) state_d = S_IDLE;
        end else if (DEF_W'(rr_len) <= def_sat) begin
          deficit_d[rr_q] = def_sat - DEF_W'(rr_len);
          cur_d           = rr_q;
          len_d           = rr_len;
          wcnt_d          = '0;
          state_d         = S_SEND;
        end else begin
          deficit_d[rr_q] = def_sat;
          rr_d            = rr_q + 1'b1;
        end
      end
      S_SEND: begin
        if (ld) begin
          if (last_word) state_d = S_NEXT;
          else           wcnt_d  = wcnt_q + 1'b1;
        end
      end
      // Bubble cycle: the popped FIFO now shows the next header, so remaining credit can be tested.
      S_NEXT: begin
        if (!fifo_empty[cur_q] && (deficit_q[cur_q] >= DEF_W'(cur_len))) begin
          deficit_d[cur_q] = deficit_q[cur_q] - DEF_W'(cur_len);
          len_d            = cur_len;
          wcnt_d           = '0;
          state_d          = S_SEND;
        end else begin
          rr_d    = cur_q + 1'b1;
          state_d = S_ARB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      cur_q       <= '0;
      wcnt_q      <= '0;
      len_q       <= '0;
      for (int i = 0; i < N; i++) deficit_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cur_q       <= cur_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      for (int i = 0; i < N; i++) deficit_q[i] <= deficit_d[i];
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

`ifdef FQ_STATS_EN
  logic [31:0] stat_pkts_q [N];
  logic [31:0] stat_pkts_d [N];
  logic [31:0] stat_words_q [N];
  logic [31:0] stat_words_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      stat_pkts_d[i]  = stat_pkts_q[i];
      stat_words_d[i] = stat_words_q[i];
    end
    if (stat_clr) begin
      for (int i = 0; i < N; i++) begin
        stat_pkts_d[i]  = '0;
        stat_words_d[i] = '0;
      end
    end else if (ld) begin
      stat_words_d[cur_q] = stat_words_q[cur_q] + 32'd1;
      if (last_word) stat_pkts_d[cur_q] = stat_pkts_q[cur_q] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stat_pkts_q[i]  <= '0;
        stat_words_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        stat_pkts_q[i]  <= stat_pkts_d[i];
        stat_words_q[i] <= stat_words_d[i];
      end
    end
  end

  assign stat_pkts  = stat_pkts_q[stat_sel];
  assign stat_words = stat_words_q[stat_sel];
`endif

endmodule

// File: tb/tb_fq_drr.sv
// tb/tb_fq_drr.sv - directed bench for fq_drr with show-ahead FIFO models and an output log
module tb_fq_drr;
  localparam int N  = 8;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    fifo_rdreq;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [2:0]      out_chan;

  logic [63:0] mem [N][256];
  int          wp [N];
  int          rp [N];
  int          eptr [N];
  int          rdq_cnt [N];
  logic [63:0] log_data [1024];
  logic        log_sop [1024];
  logic        log_eop [1024];
  logic [2:0]  log_chan [1024];
  int          log_cyc [1024];
  int          n_log;
  int          cyc;
  int          n_chk;
  int          n_err;

  fq_drr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rdreq (fifo_rdreq),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_chan   (out_chan)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]         = (rp[i] == wp[i]);
      fifo_data[i*DW +: DW] = mem[i][rp[i] % 256];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready && n_log < 1024) begin
      log_data[n_log] <= out_data;
      log_sop[n_log]  <= out_sop;
      log_eop[n_log]  <= out_eop;
      log_chan[n_log] <= out_chan;
      log_cyc[n_log]  <= cyc;
      n_log           <= n_log + 1;
    end
    for (int i = 0; i < N; i++) begin
      if (fifo_rdreq[i]) begin
        rp[i]      <= rp[i] + 1;
        rdq_cnt[i] <= rdq_cnt[i] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mkw(input int ch, input int pkt, input int idx, input int len);
    logic [63:0] w;
    w = {8'(ch), 16'(pkt), 8'(idx), 24'h5A5A5A, 8'h01};
    if (idx == 0) w[7:0] = 8'(len);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int pkt, input int len, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      mem[ch][wp[ch] % 256] = mkw(ch, pkt, i, len);
      wp[ch] = wp[ch] + 1;
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (n_log < n && k < budget) begin
      @(negedge clk);
      k = k + 1;
    end
    chk(tag, 64'(n_log), 64'(n));
  endtask

  task automatic check_stream(input int from, input int to, input string tag);
    int bad = 0;
    int c;
    for (int i = from; i < to; i++) begin
      c = int'(log_chan[i]);
      if (log_data[i] !== mem[c][eptr[c] % 256]) bad = bad + 1;
      eptr[c] = eptr[c] + 1;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          ls, base, t0, cnt, stalls, hold_bad, rd_bad, np;
    logic [3:0]  sopv, eopv;
    logic [29:0] seq;
    logic        p_v, p_r, p_s, p_e;
    logic [63:0] p_d;
    logic [2:0]  p_c;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sop",   64'(out_sop),   64'd0);
    chk("rst_eop",   64'(out_eop),   64'd0);
    chk("rst_data",  out_data,       64'd0);
    chk("rst_chan",  64'(out_chan),  64'd0);
    chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single L=4 packet on ch0
    ls = n_log; base = rdq_cnt[0]; t0 = cyc;
    push(0, 0, 4, 0, 3);
    wait_log(ls + 4, 50, "t1_count");
    repeat (3) @(negedge clk);
    sopv = {log_sop[ls+3], log_sop[ls+2], log_sop[ls+1], log_sop[ls]};
    eopv = {log_eop[ls+3], log_eop[ls+2], log_eop[ls+1], log_eop[ls]};
    chk("t1_sop", 64'(sopv), 64'b0001);
    chk("t1_eop", 64'(eopv), 64'b1000);
    chk("t1_chan", 64'(log_chan[ls] | log_chan[ls+1] | log_chan[ls+2] | log_chan[ls+3]), 64'd0);
    chk("t1_latency", 64'(log_cyc[ls] - t0), 64'd3);
    chk("t1_back_to_back", 64'(log_cyc[ls+3] - log_cyc[ls]), 64'd3);
    chk("t1_rdreq_cycles", 64'(rdq_cnt[0] - base), 64'd4);
    check_stream(ls, ls + 4, "t1_data");

    // ch0 five L=20 packets against ch1 twenty-five L=4 packets
    do_reset();
    ls = n_log;
    for (int p = 0; p < 5; p++)  push(0, p, 20, 0, 19);
    for (int p = 0; p < 25; p++) push(1, p, 4, 0, 3);
    wait_log(ls + 200, 3000, "t2_count");
    seq = '0; np = 0; cnt = 0;
    for (int i = ls; i < ls + 200; i++) begin
      if (log_sop[i]) begin
        seq = {seq[28:0], log_chan[i][0]};
        np  = np + 1;
      end
      if (i < ls + 100 && log_chan[i] == 3'd0) cnt = cnt + 1;
    end
    chk("t2_packets", 64'(np), 64'd30);
    chk("t2_order", 64'(seq), 64'(30'b111101111011110111101111111101));
    chk("t2_ch0_words_first100", 64'(cnt), 64'd52);
    check_stream(ls, ls + 200, "t2_data");

    // ready toggling every cycle through an L=8 packet on ch2
    do_reset();
    ls = n_log;
    push(2, 0, 8, 0, 7);
    stalls = 0; hold_bad = 0; rd_bad = 0;
    p_v = 1'b0; p_r = 1'b1; p_d = '0; p_s = 1'b0; p_e = 1'b0; p_c = '0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (p_v && !p_r) begin
        stalls = stalls + 1;
        if (out_valid !== 1'b1 || out_data !== p_d || out_sop !== p_s ||
            out_eop !== p_e || out_chan !== p_c) hold_bad = hold_bad + 1;
      end
      out_ready = ~out_ready;
      #1;
      if (out_valid && !out_ready && fifo_rdreq != '0) rd_bad = rd_bad + 1;
      p_v = out_valid; p_r = out_ready; p_d = out_data;
      p_s = out_sop;   p_e = out_eop;   p_c = out_chan;
    end
    out_ready = 1'b1;
    chk("t3_stalls_seen", 64'(stalls > 0), 64'd1);
    chk("t3_hold_stable", 64'(hold_bad), 64'd0);
    chk("t3_no_pop_stalled", 64'(rd_bad), 64'd0);
    chk("t3_word_count", 64'(n_log - ls), 64'd8);
    check_stream(ls, ls + 8, "t3_data");

    // ch2 runs dry after word 3 of L=6 while ch3 is waiting
    do_reset();
    ls = n_log;
    push(2, 1, 6, 0, 2);
    push(3, 0, 4, 0, 3);
    wait_log(ls + 3, 50, "t4_first3");
    chk("t4_valid_dropped", 64'(out_valid), 64'd0);
    cnt = 0; rd_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) cnt = cnt + 1;
      if (fifo_rdreq[3]) rd_bad = rd_bad + 1;
    end
    chk("t4_gap_valid", 64'(cnt), 64'd0);
    chk("t4_gap_ch3_pop", 64'(rd_bad), 64'd0);
    push(2, 1, 6, 3, 5);
    wait_log(ls + 10, 80, "t4_count");
    chk("t4_resume_chan", 64'({log_chan[ls+3], log_chan[ls+4], log_chan[ls+5]}), 64'({3'd2, 3'd2, 3'd2}));
    chk("t4_ch3_after", 64'({log_chan[ls+6], log_sop[ls+6]}), 64'({3'd3, 1'b1}));
    check_stream(ls, ls + 10, "t4_data");

    // L=0 header on ch5, followed by an L=2 packet
    do_reset();
    ls = n_log;
    push(5, 0, 0, 0, 0);
    push(5, 1, 2, 0, 1);
    wait_log(ls + 3, 60, "t5_count");
    chk("t5_single_word", 64'({log_sop[ls], log_eop[ls], log_chan[ls]}), 64'({1'b1, 1'b1, 3'd5}));
    chk("t5_next_pkt", 64'({log_sop[ls+1], log_eop[ls+1], log_sop[ls+2], log_eop[ls+2]}), 64'b1001);
    check_stream(ls, ls + 3, "t5_data");

    // reset asserted while ch4 is mid-packet
    do_reset();
    ls = n_log;
    push(4, 0, 8, 0, 7);
    wait_log(ls + 3, 50, "t6_pre_count");
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_sop",   64'(out_sop),   64'd0);
    chk("t6_async_eop",   64'(out_eop),   64'd0);
    chk("t6_async_data",  out_data,       64'd0);
    chk("t6_async_chan",  64'(out_chan),  64'd0);
    chk("t6_async_rdreq", 64'(fifo_rdreq), 64'd0);
    push(0, 9, 3, 0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_log(ls + 10, 100, "t6_post_count");
    check_stream(ls, ls + 3, "t6_pre_data");
    eptr[4] = eptr[4] + 1;
    chk("t6_restart_ch0", 64'(log_chan[ls+3]), 64'd0);
    cnt = 0;
    for (int i = ls + 6; i < ls + 10; i++)
      if (log_sop[i] && log_eop[i] && log_chan[i] == 3'd4) cnt = cnt + 1;
    chk("t6_leftover_singles", 64'(cnt), 64'd4);
    check_stream(ls + 3, ls + 10, "t6_post_data");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
